// File: rtl/wall_spawner_if.sv
// wall_spawner_if: request, generator, occupancy and query signals of the wall spawner
interface wall_spawner_if;
  logic       spawn_req;
  logic       clear_walls;
  logic [7:0] rand_xy;
  logic       rand_enable;
  logic [7:0] probe_xy;
  logic       occupied;
  logic [7:0] query_xy;
  logic       wall_hit;
  logic [3:0] wall_count;
  logic       busy;
  logic       done;
  logic       fail;
  modport master (
    output spawn_req, clear_walls, rand_xy, occupied, query_xy,
    input  rand_enable, probe_xy, wall_hit, wall_count, busy, done, fail
  );
  modport slave (
    input  spawn_req, clear_walls, rand_xy, occupied, query_xy,
    output rand_enable, probe_xy, wall_hit, wall_count, busy, done, fail
  );
endinterface

// File: rtl/wall_spawner.sv
// wall_spawner: draws random cells, rejects illegal/occupied/duplicate ones, keeps a wall table
// Optional WALL_BORDER_KEEPOUT_EN: also reject cells on the arena border.
module wall_spawner #(
  parameter int MAX_WALLS = 8,
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int MAX_TRIES = 15,
  parameter int SETTLE    = 2
) (
  input logic         system_clk,
  input logic         nreset,
  wall_spawner_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FULLCHK, S_PULSE, S_SETTLE, S_PROBE, S_CHECK} state_t;
  localparam logic [4:0] W5 = 5'(GRID_W);
  localparam logic [4:0] H5 = 5'(GRID_H);
  state_t               state, next_state;
  logic [7:0]           cap_xy;
  logic [7:0]           table_xy [MAX_WALLS];
  logic [MAX_WALLS-1:0] valid;
  logic [3:0]           count, tries;
  logic [2:0]           settle_cnt;
  logic                 dup, hit, border, accept, full, tries_out, settle_last, write_en;
  logic [4:0]           x5, y5;
  assign x5          = {1'b0, cap_xy[7:4]};
  assign y5          = {1'b0, cap_xy[3:0]};
  assign full        = count == 4'(MAX_WALLS);
  assign tries_out   = tries + 4'd1 == 4'(MAX_TRIES);
  assign settle_last = settle_cnt == 3'(SETTLE - 1);
  assign write_en    = state == S_CHECK && accept && !bus.clear_walls;
  // Table lookups: duplicate check for the captured cell and the external hit query
  always_comb begin
    dup = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < MAX_WALLS; i++) begin
      dup = dup | (valid[i] && table_xy[i] == cap_xy);
      hit = hit | (valid[i] && table_xy[i] == bus.query_xy);
    end
  end
  // Candidate acceptance: inside the grid, free, not already a wall
  always_comb begin
`ifdef WALL_BORDER_KEEPOUT_EN
    border = x5 == 5'd0 || x5 == W5 - 5'd1 || y5 == 5'd0 || y5 == H5 - 5'd1;
`else
    border = 1'b0;
`endif
    accept = x5 < W5 && y5 < H5 && !bus.occupied && !dup && !border;
  end
  // State register
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) state <= S_IDLE;
    else state <= next_state;
  // Next-state logic; a clear always returns to idle
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    next_state = bus.spawn_req ? S_FULLCHK : S_IDLE;
      S_FULLCHK: next_state = full ? S_IDLE : S_PULSE;
      S_PULSE:   next_state = S_SETTLE;
      S_SETTLE:  next_state = settle_last ? S_PROBE : S_SETTLE;
      S_PROBE:   next_state = S_CHECK;
      S_CHECK:   next_state = (accept || tries_out) ? S_IDLE : S_PULSE;
      default:   next_state = S_IDLE;
    endcase
    if (bus.clear_walls) next_state = S_IDLE;
  end
  // Datapath: settle timer, capture, retry counter, valid bits and wall count
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      cap_xy     <= '0;
      settle_cnt <= '0;
      tries      <= '0;
      valid      <= '0;
      count      <= '0;
    end else if (bus.clear_walls) begin
      valid <= '0;
      count <= '0;
    end else begin
      settle_cnt <= state == S_SETTLE ? settle_cnt + 3'd1 : 3'd0;
      if (state == S_SETTLE && settle_last) cap_xy <= bus.rand_xy;
      if (state == S_FULLCHK) tries <= '0;
      else if (state == S_CHECK && !accept) tries <= tries + 4'd1;
      if (write_en) begin
        valid <= valid | (MAX_WALLS'(1) << count);
        count <= count + 4'd1;
      end
    end
  // Table coordinates need no reset; only the valid bits qualify them
  always_ff @(posedge system_clk)
    for (int i = 0; i < MAX_WALLS; i++)
      if (write_en && count == 4'(i)) table_xy[i] <= cap_xy;
  // Outputs decoded from state; pulses suppressed by a concurrent clear
  always_comb begin
    bus.rand_enable = state == S_PULSE;
    bus.probe_xy    = state == S_IDLE ? 8'h00 : cap_xy;
    bus.busy        = state != S_IDLE;
    bus.done        = write_en;
    bus.fail        = !bus.clear_walls && ((state == S_FULLCHK && full) || (state == S_CHECK && !accept && tries_out));
    bus.wall_hit    = hit;
    bus.wall_count  = count;
  end
endmodule

// File: tb/tb_wall_spawner.sv
// tb_wall_spawner: directed checks of spawning, retries, failure, clear and reset
module tb_wall_spawner;
  logic system_clk = 1'b0;
  logic nreset = 1'b0;
  int errors = 0;
  int checks = 0;
  int p, d, f, e, n;
  logic [7:0] pr;
  wall_spawner_if bus ();
  wall_spawner dut (.system_clk(system_clk), .nreset(nreset), .bus(bus.slave));
  always #5 system_clk = ~system_clk;
  // Runs one spawn; cycle 1 is the first cycle after the edge that samples spawn_req
  task automatic run_spawn(input logic [7:0] v1, input int n1, input logic [7:0] v2,
                           output int pulses, output int done_cyc, output int fail_cyc,
                           output int ends, output logic [7:0] probe_seen);
    pulses = 0; done_cyc = 0; fail_cyc = 0; ends = 0; probe_seen = 8'h00;
    bus.rand_xy = v1;
    @(negedge system_clk); bus.spawn_req = 1'b1;
    @(negedge system_clk); bus.spawn_req = 1'b0;
    for (int c = 1; c <= 300 && ends == 0; c++) begin
      if (c > 1) @(negedge system_clk);
      if (bus.rand_enable) begin pulses++; if (pulses > n1) bus.rand_xy = v2; end
      if (bus.done) begin done_cyc = c; ends++; probe_seen = bus.probe_xy; end
      if (bus.fail) begin fail_cyc = c; ends++; end
    end
    @(negedge system_clk);
  endtask
  task automatic pulse_clear();
    @(negedge system_clk); bus.clear_walls = 1'b1;
    @(negedge system_clk); bus.clear_walls = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge system_clk);
    bus.query_xy = 8'h35; #1;
    checks++; if (bus.wall_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.wall_hit); end
    checks++; if (bus.wall_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.wall_count); end
    checks++; if ({bus.busy, bus.done, bus.fail, bus.rand_enable} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.fail, bus.rand_enable}); end
    checks++; if (bus.probe_xy !== 8'h00) begin errors++; $display("FAIL reset_probe: got %h want 00", bus.probe_xy); end
    @(negedge system_clk); nreset = 1'b1;
  endtask
  task automatic test_basic();
    run_spawn(8'h35, 99, 8'h35, p, d, f, e, pr);
    checks++; if (p !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", p); end
    checks++; if (d !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", d); end
    checks++; if (f !== 0) begin errors++; $display("FAIL basic_fail: got cycle %0d want none", f); end
    checks++; if (pr !== 8'h35) begin errors++; $display("FAIL basic_probe: got %h want 35", pr); end
    checks++; if (bus.wall_count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", bus.wall_count); end
    bus.query_xy = 8'h35; #1;
    checks++; if (bus.wall_hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", bus.wall_hit); end
    bus.query_xy = 8'h36; #1;
    checks++; if (bus.wall_hit !== 1'b0) begin errors++; $display("FAIL basic_nohit: got %b want 0", bus.wall_hit); end
  endtask
  task automatic test_retry();
    run_spawn(8'h3F, 14, 8'h42, p, d, f, e, pr);
    checks++; if (p !== 15) begin errors++; $display("FAIL retry_pulses: got %0d want 15", p); end
    checks++; if (d !== 76) begin errors++; $display("FAIL retry_latency: got %0d want 76", d); end
    checks++; if (f !== 0) begin errors++; $display("FAIL retry_fail: got cycle %0d want none", f); end
    checks++; if (bus.wall_count !== 4'd2) begin errors++; $display("FAIL retry_count: got %0d want 2", bus.wall_count); end
    bus.query_xy = 8'h42; #1;
    checks++; if (bus.wall_hit !== 1'b1) begin errors++; $display("FAIL retry_hit42: got %b want 1", bus.wall_hit); end
    bus.query_xy = 8'h3F; #1;
    checks++; if (bus.wall_hit !== 1'b0) begin errors++; $display("FAIL retry_hit3f: got %b want 0", bus.wall_hit); end
  endtask
  task automatic test_tries();
    bus.occupied = 1'b1;
    run_spawn(8'h50, 99, 8'h50, p, d, f, e, pr);
    bus.occupied = 1'b0;
    checks++; if (p !== 15) begin errors++; $display("FAIL tries_pulses: got %0d want 15", p); end
    checks++; if (f !== 76) begin errors++; $display("FAIL tries_fail_cycle: got %0d want 76", f); end
    checks++; if (d !== 0) begin errors++; $display("FAIL tries_done: got cycle %0d want none", d); end
    checks++; if (bus.wall_count !== 4'd2) begin errors++; $display("FAIL tries_count: got %0d want 2", bus.wall_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tries_busy: got %b want 0", bus.busy); end
  endtask
  task automatic test_full();
    pulse_clear();
    checks++; if (bus.wall_count !== 4'd0) begin errors++; $display("FAIL full_preclear: got %0d want 0", bus.wall_count); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      run_spawn(8'h11 + 8'(i), 99, 8'h11 + 8'(i), p, d, f, e, pr);
      if (d == 6) n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL full_dones: got %0d want 8", n); end
    checks++; if (bus.wall_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", bus.wall_count); end
    run_spawn(8'h19, 99, 8'h19, p, d, f, e, pr);
    checks++; if (f !== 1) begin errors++; $display("FAIL full_fail_cycle: got %0d want 1", f); end
    checks++; if (p !== 0) begin errors++; $display("FAIL full_pulses: got %0d want 0", p); end
    checks++; if (bus.wall_count !== 4'd8) begin errors++; $display("FAIL full_count_after: got %0d want 8", bus.wall_count); end
    pulse_clear();
    bus.query_xy = 8'h14; #1;
    checks++; if (bus.wall_count !== 4'd0) begin errors++; $display("FAIL full_clear_count: got %0d want 0", bus.wall_count); end
    checks++; if (bus.wall_hit !== 1'b0) begin errors++; $display("FAIL full_clear_hit: got %b want 0", bus.wall_hit); end
  endtask
  task automatic test_dup();
    run_spawn(8'h22, 99, 8'h22, p, d, f, e, pr);
    run_spawn(8'h22, 3, 8'h23, p, d, f, e, pr);
    checks++; if (p !== 4) begin errors++; $display("FAIL dup_pulses: got %0d want 4", p); end
    checks++; if (d !== 21) begin errors++; $display("FAIL dup_latency: got %0d want 21", d); end
    checks++; if (bus.wall_count !== 4'd2) begin errors++; $display("FAIL dup_count: got %0d want 2", bus.wall_count); end
    bus.query_xy = 8'h23; #1;
    checks++; if (bus.wall_hit !== 1'b1) begin errors++; $display("FAIL dup_hit23: got %b want 1", bus.wall_hit); end
  endtask
  task automatic test_clear_mid();
    bus.rand_xy = 8'h77;
    @(negedge system_clk); bus.spawn_req = 1'b1;
    @(negedge system_clk); bus.spawn_req = 1'b0;
    repeat (4) @(negedge system_clk);
    checks++; if (bus.probe_xy !== 8'h77) begin errors++; $display("FAIL clrmid_probe: got %h want 77", bus.probe_xy); end
    bus.clear_walls = 1'b1;
    @(negedge system_clk); bus.clear_walls = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clrmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.wall_count !== 4'd0) begin errors++; $display("FAIL clrmid_count: got %0d want 0", bus.wall_count); end
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge system_clk); if (bus.done || bus.busy) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL clrmid_activity: got %0d want 0", n); end
  endtask
  task automatic test_clear_vs_spawn();
    @(negedge system_clk); bus.spawn_req = 1'b1; bus.clear_walls = 1'b1;
    @(negedge system_clk); bus.spawn_req = 1'b0; bus.clear_walls = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clrspawn_busy: got %b want 0", bus.busy); end
    @(negedge system_clk);
    checks++; if ({bus.busy, bus.rand_enable, bus.fail} !== 3'b0) begin errors++; $display("FAIL clrspawn_later: got %b want 000", {bus.busy, bus.rand_enable, bus.fail}); end
  endtask
  task automatic test_border();
`ifdef WALL_BORDER_KEEPOUT_EN
    run_spawn(8'h05, 1, 8'h66, p, d, f, e, pr);
    checks++; if (p !== 2) begin errors++; $display("FAIL border_pulses: got %0d want 2", p); end
    bus.query_xy = 8'h05; #1;
    checks++; if (bus.wall_hit !== 1'b0) begin errors++; $display("FAIL border_hit05: got %b want 0", bus.wall_hit); end
`else
    run_spawn(8'h05, 99, 8'h05, p, d, f, e, pr);
    checks++; if (p !== 1) begin errors++; $display("FAIL border_pulses: got %0d want 1", p); end
    bus.query_xy = 8'h05; #1;
    checks++; if (bus.wall_hit !== 1'b1) begin errors++; $display("FAIL border_hit05: got %b want 1", bus.wall_hit); end
`endif
    checks++; if (bus.wall_count !== 4'd1) begin errors++; $display("FAIL border_count: got %0d want 1", bus.wall_count); end
  endtask
  task automatic test_reset_mid();
    bus.rand_xy = 8'h44;
    @(negedge system_clk); bus.spawn_req = 1'b1;
    @(negedge system_clk); bus.spawn_req = 1'b0;
    repeat (2) @(negedge system_clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    nreset = 1'b0; #1;
    checks++; if ({bus.busy, bus.rand_enable, bus.done, bus.fail} !== 4'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {bus.busy, bus.rand_enable, bus.done, bus.fail}); end
    checks++; if (bus.wall_count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.wall_count); end
    checks++; if (bus.probe_xy !== 8'h00) begin errors++; $display("FAIL rstmid_probe: got %h want 00", bus.probe_xy); end
    @(negedge system_clk); nreset = 1'b1;
  endtask
  initial begin
    bus.spawn_req = 1'b0; bus.clear_walls = 1'b0; bus.rand_xy = 8'h00;
    bus.occupied = 1'b0; bus.query_xy = 8'h00;
    test_reset();
    test_basic();
    test_retry();
    test_tries();
    test_full();
    test_dup();
    test_clear_mid();
    test_clear_vs_spawn();
    test_border();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wall_spawner.md
Name: wall_spawner

Overview:
- Consumer of the wall-mode random coordinate generator in the snake game.
- On request, pulses the generator's enable, captures the 8-bit coordinate ({x[3:0], y[3:0]}) and probes the game's occupancy logic. A free, in-bounds cell is stored in a wall table; otherwise it retries.
- Serves combinational wall-hit queries to the collision/draw logic.

Parameters:
- MAX_WALLS, 8, wall table depth; legal range 1..15.
- GRID_W, 16, legal x range 0..GRID_W-1.
- GRID_H, 12, legal y range 0..GRID_H-1.
- MAX_TRIES, 15, rejected draws allowed per spawn before failing; legal range 1..15.
- SETTLE, 2, cycles waited after the enable pulse before sampling rand_xy; legal range 1..7.

Ports:
- system_clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- spawn_req  in  1  one-cycle pulse; request one new wall
- clear_walls  in  1  synchronous clear of the table; wins over all other activity
- rand_xy  in  8  generator output, [7:4]=x, [3:0]=y
- rand_enable  out  1  one-cycle pulse to the generator; its rising edge produces a new number
- probe_xy  out  8  cell currently checked by the occupancy logic
- occupied  in  1  combinational answer for probe_xy (snake body, head or apple)
- query_xy  in  8  cell queried by collision/draw logic
- wall_hit  out  1  combinational; query_xy matches a valid wall entry
- wall_count  out  4  number of valid walls
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: wall stored
- fail  out  1  one-cycle pulse: spawn abandoned (table full or tries exhausted)

Behaviour:
- Reset (async, nreset low):
  - state=IDLE; all outputs 0; wall_count=0; all valid bits 0; try counter 0.
  - Table coordinates are don't-care.
- States: IDLE, PULSE, SETTLE, PROBE, CHECK, FULLCHK.
- IDLE:
  - spawn_req=1 -> FULLCHK. A spawn_req seen while busy=1 is ignored; it is not queued.
- FULLCHK:
  - wall_count==MAX_WALLS -> fail=1 for one cycle, then IDLE.
  - Otherwise -> PULSE with try counter cleared to 0.
- PULSE:
  - rand_enable=1 for exactly this one cycle -> SETTLE with settle counter cleared.
- SETTLE:
  - rand_enable=0; count SETTLE cycles, then register rand_xy into cap_xy -> PROBE.
- PROBE:
  - probe_xy=cap_xy. probe_xy holds cap_xy whenever it is not IDLE; it is 0 in IDLE.
  - Wait one cycle for occupied -> CHECK.
- CHECK: rejected if any of the following holds:
  - x>=GRID_W;
  - y>=GRID_H;
  - occupied=1;
  - cap_xy equals a valid table entry.
- CHECK, rejected:
  - try counter++.
  - If the incremented count == MAX_TRIES -> fail pulse, IDLE; else -> PULSE.
- CHECK, accepted:
  - Write cap_xy to slot wall_count, set its valid bit, wall_count++.
  - done pulse -> IDLE.
- Latency:
  - Best-case spawn_req to done = 1 (FULLCHK) + 1 (PULSE) + SETTLE + 1 (PROBE) + 1 (CHECK) = 6 cycles at SETTLE=2.
  - Each retry adds SETTLE+3 cycles.
- clear_walls:
  - Next edge: all valid bits 0, wall_count=0, state=IDLE, no done/fail pulse.
  - If it arrives mid-spawn, the spawn is aborted.
  - Simultaneous with spawn_req: clear wins and the request is dropped.
- wall_hit:
  - Purely combinational OR over the valid entries; not gated by state.
  - A wall written on edge N is visible to queries from cycle N+1.
- Arithmetic:
  - Comparisons are unsigned on 4-bit fields.
  - wall_count never exceeds MAX_WALLS; the table never wraps.

Optional Feature:
- Macro: WALL_BORDER_KEEPOUT_EN.
- Defined: CHECK additionally rejects x==0, x==GRID_W-1, y==0 or y==GRID_H-1, so walls never spawn on the arena border.
- Undefined: border cells are legal when otherwise free.

Test Plan:
- Reset, then query_xy=8'h35 -> wall_hit=0, wall_count=0, busy=0. spawn_req with rand_xy held at 8'h35 and occupied=0 -> rand_enable pulses once, done exactly 6 cycles after spawn_req, wall_count=1, query 8'h35 -> wall_hit=1.
- rand_xy=8'h3F (y=15 >= 12) for 14 draws, then 8'h42 -> 14 extra rand_enable pulses, done, stored 8'h42, fail never asserted.
- occupied forced 1 -> exactly 15 rand_enable pulses, then a fail pulse, wall_count unchanged, busy=0.
- Eight successful spawns at distinct cells 8'h11..8'h18, then a ninth spawn_req -> fail 1 cycle after the request with no rand_enable pulse. Then clear_walls -> wall_count=0 and a query of 8'h14 gives wall_hit=0.
- Store 8'h22, then spawn again with rand_xy=8'h22 for three draws, then 8'h23 -> duplicate rejected, done, two walls stored.
- nreset asserted while in SETTLE -> outputs 0 immediately and wall_count=0. clear_walls during PROBE -> IDLE, no done. With WALL_BORDER_KEEPOUT_EN defined, rand_xy=8'h05 (x=0) is rejected.
